// File: rtl/fs_pkg.sv
// rtl/fs_pkg.sv - shared geometry, widths and FSM encoding for the FAST9 NMS stage
package fs_pkg;
  localparam int IMG_W     = 160;
  localparam int IMG_H     = 120;
  localparam int ADDR_W    = 15;
  localparam int SCORE_W   = 8;
  localparam int COL_W     = $clog2(IMG_W);
  localparam int ROW_W     = $clog2(IMG_H);
  localparam int LAST_ADDR = IMG_W * IMG_H - 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} nmsState;
endpackage

// File: rtl/fs_nms_linebuf.sv
// rtl/fs_nms_linebuf.sv - one image row of score delay, advancing only when enabled
module fs_nms_linebuf
  import fs_pkg::*;
(
  input  logic               clock,
  input  logic               nReset,
  input  logic               en,
  input  logic [SCORE_W-1:0] pixel,
  output logic [SCORE_W-1:0] delayed
);
  logic [SCORE_W-1:0] taps [IMG_W];

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < IMG_W; i++) taps[i] <= '0;
    end else if (en) begin
      taps[0] <= pixel;
      for (int i = 1; i < IMG_W; i++) taps[i] <= taps[i-1];
    end
  end

  assign delayed = taps[IMG_W-1];
endmodule

// File: rtl/fs_nms_scan.sv
// rtl/fs_nms_scan.sv - raster-scans the score SRAM and streams 3x3 non-maximum-suppressed corners
module fs_nms_scan
  import fs_pkg::*;
(
  input  logic               clock,
  input  logic               nReset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  rdAddr,
  input  logic [SCORE_W-1:0] rdData,
  output logic               cornerValid,
  input  logic               cornerReady,
  output logic [ADDR_W-1:0]  cornerAddr,
  output logic [SCORE_W-1:0] cornerScore,
  output logic [15:0]        cornerCount
);
  nmsState                     state;
  logic                        pend;
  logic                        holdValid;
  logic [SCORE_W-1:0]          holdData;
  logic [SCORE_W-1:0]          pixel;
  logic [SCORE_W-1:0]          rowAbove;
  logic [SCORE_W-1:0]          rowAbove2;
  logic [COL_W-1:0]            inCol;
  logic [ROW_W-1:0]            inRow;
  logic [ADDR_W-1:0]           inAddr;
  logic [2:0][SCORE_W-1:0]     colA;
  logic [2:0][SCORE_W-1:0]     colB;
  logic [SCORE_W-1:0]          center;
  logic                        stall;
  logic                        issue;
  logic                        consume;
  logic                        qualify;
  logic                        lastPixel;

  assign stall     = cornerValid && !cornerReady;
  assign issue     = (state == SCAN) && !stall;
  // Data returned during the first stalled cycle is parked in holdData, since rdAddr has already moved on.
  assign pixel     = holdValid ? holdData : rdData;
  assign consume   = (holdValid || pend) && !stall;
  assign lastPixel = (inAddr == ADDR_W'(LAST_ADDR));

  fs_nms_linebuf lineBuf1 (
    .clock  (clock),
    .nReset (nReset),
    .en     (consume),
    .pixel  (pixel),
    .delayed(rowAbove)
  );

  fs_nms_linebuf lineBuf2 (
    .clock  (clock),
    .nReset (nReset),
    .en     (consume),
    .pixel  (rowAbove),
    .delayed(rowAbove2)
  );

  // Window columns: colA = col-2, colB = col-1, incoming column = {rowAbove2, rowAbove, pixel}; index 0 is the top row.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      colA <= '0;
      colB <= '0;
    end else if (consume) begin
      colA    <= colB;
      colB[0] <= rowAbove2;
      colB[1] <= rowAbove;
      colB[2] <= pixel;
    end
  end

  assign center = colB[1];

  // Strict against raster-earlier neighbours, non-strict against later ones, so one plateau pixel survives.
  assign qualify = consume && (inRow >= ROW_W'(2)) && (inCol >= COL_W'(2)) && (center != '0)
                   && (center >  colA[0]) && (center >  colB[0]) && (center >  rowAbove2)
                   && (center >  colA[1]) && (center >= rowAbove)
                   && (center >= colA[2]) && (center >= colB[2]) && (center >= pixel);

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      rdAddr      <= '0;
      pend        <= 1'b0;
      holdValid   <= 1'b0;
      holdData    <= '0;
      inCol       <= '0;
      inRow       <= '0;
      inAddr      <= '0;
      cornerValid <= 1'b0;
      cornerAddr  <= '0;
      cornerScore <= '0;
      cornerCount <= '0;
    end else begin
      done <= 1'b0;
      pend <= issue;

      if (stall && pend) begin
        holdValid <= 1'b1;
        holdData  <= rdData;
      end else if (consume) begin
        holdValid <= 1'b0;
      end

      if (consume) begin
        inAddr <= inAddr + ADDR_W'(1);
        if (inCol == COL_W'(IMG_W - 1)) begin
          inCol <= '0;
          inRow <= inRow + ROW_W'(1);
        end else begin
          inCol <= inCol + COL_W'(1);
        end
      end

      if (qualify) begin
        cornerValid <= 1'b1;
        cornerAddr  <= inAddr - ADDR_W'(IMG_W + 1);
        cornerScore <= center;
      end else if (cornerValid && cornerReady) begin
        cornerValid <= 1'b0;
      end

      if (cornerValid && cornerReady && (cornerCount != 16'hFFFF))
        cornerCount <= cornerCount + 16'd1;

      case (state)
        IDLE: if (start) begin
          state       <= SCAN;
          busy        <= 1'b1;
          rdAddr      <= '0;
          cornerCount <= '0;
          inCol       <= '0;
          inRow       <= '0;
          inAddr      <= '0;
          holdValid   <= 1'b0;
        end
        SCAN: if (issue) begin
          if (rdAddr == ADDR_W'(LAST_ADDR)) state  <= DRAIN;
          else                              rdAddr <= rdAddr + ADDR_W'(1);
        end
        DRAIN: if (consume && lastPixel) state <= FINISH;
        FINISH: if (!cornerValid) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
